uart_rx_parity: RTL and testbench

UART receiver paired with the team's even-parity UART transmitter: recovers frames of 1 start bit, 8 data bits LSB-first, 1 even-parity bit and 1 stop bit from an asynchronous serial line. It samples each bit at mid-period using an internal bit timer driven by the same `count` divisor word the transmitter uses. It delivers each received byte with a one-cycle valid strobe plus parity and framing status. It sits between the pad/serial input and the byte-level consumer logic.

---
 rtl/uart_rx_parity.sv | 157 +++++++++++++++
 tb/tb_uart_rx_parity.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8E1 UART receiver with mid-bit sampling and parity/framing status.
// The bit period is count+1 clocks and is latched at start detect, so it always matches the companion transmitter.
module uart_rx_parity (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count,
   input  logic       serial_in,
   output logic [7:0] rx_byte,
   output logic       rx_dv,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_active
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t     r_state, w_state_next;
   logic       r_sync1, r_sync2;
   logic [7:0] r_count, w_count_next;
   logic [7:0] r_timer, w_timer_next;
   logic [2:0] r_index, w_index_next;
   logic [7:0] r_shift, w_shift_next;
   logic       r_par_bit, w_par_bit_next;
   logic [7:0] r_rx_byte, w_rx_byte_next;
   logic       r_rx_dv, w_rx_dv_next;
   logic       r_parity_err, w_parity_err_next;
   logic       r_frame_err, w_frame_err_next;

   logic       w_rx_s;
   logic       w_bit_end;
   logic       w_half_hit;

   assign w_rx_s     = r_sync2;
   assign w_bit_end  = (r_timer == r_count);
   assign w_half_hit = (r_timer == {1'b0, r_count[7:1]});

   // The synchronizer resets to the idle-high line level so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_count      <= 8'd0;
         r_timer      <= 8'd0;
         r_index      <= 3'd0;
         r_shift      <= 8'd0;
         r_par_bit    <= 1'b0;
         r_rx_byte    <= 8'd0;
         r_rx_dv      <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_count      <= w_count_next;
         r_timer      <= w_timer_next;
         r_index      <= w_index_next;
         r_shift      <= w_shift_next;
         r_par_bit    <= w_par_bit_next;
         r_rx_byte    <= w_rx_byte_next;
         r_rx_dv      <= w_rx_dv_next;
         r_parity_err <= w_parity_err_next;
         r_frame_err  <= w_frame_err_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_count_next      = r_count;
      w_timer_next      = r_timer + 8'd1;
      w_index_next      = r_index;
      w_shift_next      = r_shift;
      w_par_bit_next    = r_par_bit;
      w_rx_byte_next    = r_rx_byte;
      w_rx_dv_next      = 1'b0;
      w_parity_err_next = r_parity_err;
      w_frame_err_next  = r_frame_err;

      case (r_state)
         S_IDLE: begin
            w_timer_next = 8'd0;
            if (!w_rx_s) begin
               w_state_next = S_START;
               w_count_next = count;
            end
         end
         S_START: begin
            // A start bit that is already high again at its midpoint was a glitch
            if (w_half_hit) begin
               w_timer_next = 8'd0;
               w_index_next = 3'd0;
               w_state_next = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_timer_next = 8'd0;
               w_shift_next = {w_rx_s, r_shift[7:1]};
               w_index_next = r_index + 3'd1;
               if (r_index == 3'd7) begin
                  w_state_next = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_timer_next   = 8'd0;
               w_par_bit_next = w_rx_s;
               w_state_next   = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_timer_next      = 8'd0;
               w_rx_byte_next    = r_shift;
               w_parity_err_next = (^r_shift) ^ r_par_bit;
               w_frame_err_next  = ~w_rx_s;
               w_rx_dv_next      = 1'b1;
               // A low stop bit means break or held-low line: wait for idle before rearming
               w_state_next      = w_rx_s ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            w_timer_next = 8'd0;
            if (w_rx_s) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_timer_next = 8'd0;
         end
      endcase
   end

   assign rx_byte    = r_rx_byte;
   assign rx_dv      = r_rx_dv;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign rx_active  = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed self-checking bench for uart_rx_parity: clean frames, parity and framing errors,
// start glitch, back-to-back frames and reset abort.
module tb_uart_rx_parity;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] count;
   logic       serial_in;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       parity_err;
   logic       frame_err;
   logic       rx_active;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;

   int         dv_cyc[$];
   logic [7:0] dv_byte[$];
   logic       dv_perr[$];
   logic       dv_ferr[$];

   uart_rx_parity dut (
      .clk        (clk),
      .rst        (rst),
      .count      (count),
      .serial_in  (serial_in),
      .rx_byte    (rx_byte),
      .rx_dv      (rx_dv),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .rx_active  (rx_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle with rx_dv high is logged, so a stretched pulse shows up as an extra entry
   always @(negedge clk) begin
      if (rx_dv === 1'b1) begin
         dv_cyc.push_back(cyc);
         dv_byte.push_back(rx_byte);
         dv_perr.push_back(parity_err);
         dv_ferr.push_back(frame_err);
         $display("rx_dv at cycle %0d: byte=%02h parity_err=%0b frame_err=%0b",
                  cyc, rx_byte, parity_err, frame_err);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      dv_cyc.delete();
      dv_byte.delete();
      dv_perr.delete();
      dv_ferr.delete();
   endtask

   // Called #1 after a rising edge; the next edge is edge 0. Bits: start, d0..d7, parity, stop.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int p);
      logic [10:0] bits;
      bits = {stp, par, b, 1'b0};
      t0 = cyc + 1;
      for (int i = 0; i < 11; i++) begin
         serial_in = bits[i];
         repeat (p) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      count = 8'd15;
      serial_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rx_byte, rx_dv, parity_err, frame_err, rx_active} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got byte=%02h dv=%b pe=%b fe=%b act=%b, want all 0",
                  rx_byte, rx_dv, parity_err, frame_err, rx_active);
      end
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (rx_active !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: rx_active=%b want 0", rx_active);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int act_err;
      count = 8'd15;
      clear_log();
      act_err = 0;
      fork
         send_frame(8'hA5, 1'b0, 1'b1, 16);
         begin
            #2;
            for (int k = 0; k < 176; k++) begin
               int  rel;
               logic exp_act;
               @(negedge clk);
               rel = cyc - t0;
               exp_act = (rel >= 2 && rel <= 169);
               checks++;
               if (rx_active !== exp_act) begin
                  errors++;
                  $display("FAIL basic_rx_active rel_edge=%0d: got %b want %b", rel, rx_active, exp_act);
               end
            end
         end
      join
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 1) begin
         errors++;
         $display("FAIL basic_dv_count: got %0d want 1", dv_cyc.size());
      end else begin
         checks++;
         if (dv_cyc[0] != t0 + 170) begin
            errors++;
            $display("FAIL basic_dv_time: got edge %0d want %0d", dv_cyc[0] - t0, 170);
         end
         checks++;
         if ({dv_byte[0], dv_perr[0], dv_ferr[0]} !== {8'hA5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_data: got byte=%02h pe=%b fe=%b want A5 0 0",
                     dv_byte[0], dv_perr[0], dv_ferr[0]);
         end
      end
      checks++;
      if (rx_byte !== 8'hA5) begin
         errors++;
         $display("FAIL basic_hold: rx_byte=%02h want A5 after rx_dv", rx_byte);
      end
      $display("test_basic done");
   endtask

   task automatic test_parity();
      count = 8'd15;
      clear_log();
      send_frame(8'h07, 1'b0, 1'b1, 16);
      send_frame(8'h07, 1'b1, 1'b1, 16);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 2) begin
         errors++;
         $display("FAIL parity_dv_count: got %0d want 2", dv_cyc.size());
      end else begin
         checks++;
         if ({dv_byte[0], dv_perr[0], dv_ferr[0]} !== {8'h07, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL parity_bad: got byte=%02h pe=%b fe=%b want 07 1 0",
                     dv_byte[0], dv_perr[0], dv_ferr[0]);
         end
         checks++;
         if ({dv_byte[1], dv_perr[1], dv_ferr[1]} !== {8'h07, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL parity_good: got byte=%02h pe=%b fe=%b want 07 0 0",
                     dv_byte[1], dv_perr[1], dv_ferr[1]);
         end
      end
      $display("test_parity done");
   endtask

   task automatic test_frame_err();
      int t0f;
      count = 8'd15;
      clear_log();
      send_frame(8'h3C, 1'b0, 1'b0, 16);
      t0f = t0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 1) begin
         errors++;
         $display("FAIL frame_dv_count: got %0d want 1", dv_cyc.size());
      end else begin
         checks++;
         if ({dv_byte[0], dv_perr[0], dv_ferr[0]} !== {8'h3C, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL frame_data: got byte=%02h pe=%b fe=%b want 3C 0 1",
                     dv_byte[0], dv_perr[0], dv_ferr[0]);
         end
         checks++;
         if (dv_cyc[0] != t0f + 170) begin
            errors++;
            $display("FAIL frame_dv_time: got edge %0d want 170", dv_cyc[0] - t0f);
         end
      end
      checks++;
      if (rx_active !== 1'b0) begin
         errors++;
         $display("FAIL frame_wait_high: rx_active=%b want 0 while line held low", rx_active);
      end
      serial_in = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 1) begin
         errors++;
         $display("FAIL frame_no_retrigger: got %0d rx_dv want 1", dv_cyc.size());
      end
      send_frame(8'h81, 1'b0, 1'b1, 16);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 2) begin
         errors++;
         $display("FAIL frame_recover_count: got %0d want 2", dv_cyc.size());
      end else begin
         checks++;
         if ({dv_byte[1], dv_perr[1], dv_ferr[1]} !== {8'h81, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL frame_recover_data: got byte=%02h pe=%b fe=%b want 81 0 0",
                     dv_byte[1], dv_perr[1], dv_ferr[1]);
         end
      end
      $display("test_frame_err done");
   endtask

   task automatic test_glitch();
      count = 8'd15;
      clear_log();
      @(posedge clk);
      #1;
      t0 = cyc + 1;
      serial_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      serial_in = 1'b1;
      @(negedge clk);
      checks++;
      if (rx_active !== 1'b1) begin
         errors++;
         $display("FAIL glitch_active: rx_active=%b at edge %0d want 1", rx_active, cyc - t0);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (rx_active !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject: rx_active=%b at edge %0d want 0", rx_active, cyc - t0);
      end
      repeat (200) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 0) begin
         errors++;
         $display("FAIL glitch_no_dv: got %0d rx_dv want 0", dv_cyc.size());
      end
      $display("test_glitch done");
   endtask

   task automatic test_back_to_back();
      int t0a;
      count = 8'd7;
      clear_log();
      send_frame(8'h00, 1'b0, 1'b1, 8);
      t0a = t0;
      send_frame(8'hFF, 1'b0, 1'b1, 8);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 2) begin
         errors++;
         $display("FAIL b2b_dv_count: got %0d want 2", dv_cyc.size());
      end else begin
         checks++;
         if (dv_cyc[0] != t0a + 86) begin
            errors++;
            $display("FAIL b2b_first_time: got edge %0d want 86", dv_cyc[0] - t0a);
         end
         checks++;
         if (dv_cyc[1] - dv_cyc[0] != 88) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 88", dv_cyc[1] - dv_cyc[0]);
         end
         checks++;
         if ({dv_byte[0], dv_perr[0], dv_ferr[0], dv_byte[1], dv_perr[1], dv_ferr[1]}
             !== {8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_data: got %02h/%b/%b %02h/%b/%b want 00/0/0 FF/0/0",
                     dv_byte[0], dv_perr[0], dv_ferr[0], dv_byte[1], dv_perr[1], dv_ferr[1]);
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      count = 8'd15;
      clear_log();
      @(posedge clk);
      #1;
      t0 = cyc + 1;
      serial_in = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (rx_active !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_frame: rx_active=%b want 1 before reset", rx_active);
      end
      rst = 1'b1;
      serial_in = 1'b1;
      #1;
      checks++;
      if ({rx_byte, rx_dv, parity_err, frame_err, rx_active} !== 12'h000) begin
         errors++;
         $display("FAIL rstmid_outputs: got byte=%02h dv=%b pe=%b fe=%b act=%b, want all 0",
                  rx_byte, rx_dv, parity_err, frame_err, rx_active);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 0) begin
         errors++;
         $display("FAIL rstmid_no_dv: got %0d rx_dv want 0", dv_cyc.size());
      end
      send_frame(8'h5A, 1'b0, 1'b1, 16);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc.size() != 1) begin
         errors++;
         $display("FAIL rstmid_dv_count: got %0d want 1", dv_cyc.size());
      end else begin
         checks++;
         if ({dv_byte[0], dv_perr[0], dv_ferr[0]} !== {8'h5A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_data: got byte=%02h pe=%b fe=%b want 5A 0 0",
                     dv_byte[0], dv_perr[0], dv_ferr[0]);
         end
         checks++;
         if (dv_cyc[0] != t0 + 170) begin
            errors++;
            $display("FAIL rstmid_dv_time: got edge %0d want 170", dv_cyc[0] - t0);
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
